prbs_stream_checker: RTL and testbench
======================================

Name: prbs_stream_checker

Overview:
- Consumes the serial bit stream from the 5-stage LFSR generator and checks it against the recurrence s[n] = s[n-4] XOR s[n-5].
- Self-synchronises by seeding from the received stream, confirms lock, then counts bit errors.
- Declares loss of lock on a run of consecutive errors.
- Sits directly downstream of the generator on the same clock. Status outputs feed the test/monitor logic.

Parameters:
- LOCK_COUNT, 8: consecutive correct predictions required in VERIFY before `locked` asserts. Range 1..255.
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force a return to SEED. Range 1..15.
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- reset, input, 1: asynchronous, active-low reset. Asserts immediately; releases synchronously to clk.
- bit_in, input, 1: received serial bit (the generator output).
- bit_valid, input, 1: bit_in is sampled only on cycles where bit_valid=1. Tie high for a continuous stream.
- clear_cnt, input, 1: synchronous clear of err_count.
- locked, output, 1: high while in LOCKED.
- error_pulse, output, 1: one-cycle pulse per mismatched bit while in LOCKED.
- err_count, output, ERR_CNT_W: saturating count of mismatches seen in LOCKED.
- state_o, output, 2: current state for debug. SEED=0, VERIFY=1, LOCKED=2.

Behaviour:
- Reset values (reset=0): state=SEED, hist[4:0]=0, seed_cnt=0, match_cnt=0, miss_cnt=0, locked=0, error_pulse=0, err_count=0, state_o=0.
- hist holds the last 5 accepted bits; hist[0] is the newest. Prediction p = hist[3] XOR hist[4].
- All state updates happen only on cycles with bit_valid=1, except clear_cnt and the clearing of error_pulse.
- All outputs are registered. The effect of a bit sampled at edge k is visible after edge k.
- SEED:
  - Shift bit_in into hist; seed_cnt increments.
  - On the 5th bit: if the new hist is all zeros, reset seed_cnt to 0 and stay in SEED (zero-lockup guard). Otherwise go to VERIFY with match_cnt=0.
- VERIFY:
  - Compare bit_in with p, then shift bit_in into hist.
  - Match: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and assert locked.
  - Mismatch: go to SEED, seed_cnt=0, and start reseeding with this bit (it counts as seed bit 1).
  - No errors are counted in this state.
- LOCKED:
  - Compare bit_in with p, then shift p (not bit_in) into hist, so one corrupted bit yields exactly one error.
  - Mismatch: error_pulse=1 on the next cycle; err_count++ (saturates at all-ones); miss_cnt++.
  - Match: miss_cnt=0.
  - When miss_cnt reaches LOSS_THRESH: go to SEED, deassert locked, seed_cnt=0, miss_cnt=0. err_count keeps its value.
- error_pulse is high for exactly one cycle per error. It is low on cycles with bit_valid=0.
- clear_cnt=1 sets err_count to 0 on the next edge. If an error occurs in the same cycle, clear wins (count=0) but error_pulse still asserts.
- Reset mid-operation: all state returns to reset values immediately. Resynchronisation restarts from SEED.
- bit_valid gaps of any length do not disturb state or counters.

Test Plan:
- Reset seed stream, continuous. Drive the generator's post-reset output 0,0,1,1,0,0,1,0,1,0,1,... with bit_valid=1 → state_o=1 after the 5th bit; locked=1 after the 13th bit (5+8); err_count stays 0 over 200 bits.
- Single-bit error. After lock, invert one bit → exactly one error_pulse; err_count=1; locked remains 1; following bits produce no further errors.
- Loss of lock. After lock, invert 3 consecutive bits → error_pulse on each; err_count=3; locked=0 and state_o=0 after the 3rd; a clean stream then relocks 13 valid bits later.
- Zero stream. bit_in=0 for 50 cycles → state_o stays 0, locked=0, err_count=0.
- Saturation and clear. With ERR_CNT_W=4, force 20 isolated errors → err_count=15. Pulse clear_cnt in the same cycle as an error → err_count=0 and error_pulse=1.
- Gapped valid and mid-run reset. Toggle bit_valid every other cycle → same lock point counted in valid bits. Assert reset while LOCKED → all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_stream_checker.sv
// rtl/prbs_stream_checker.sv - self-synchronising checker for the s[n] = s[n-4] ^ s[n-5] PRBS stream
module prbs_stream_checker #(
    parameter int LOCK_COUNT  = 8,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]           LOCK_CNT_L = 8'(LOCK_COUNT);
    localparam logic [3:0]           LOSS_THR_L = 4'(LOSS_THRESH);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [4:0]             hist_q;
    logic [2:0]             seed_cnt_q;
    logic [7:0]             match_cnt_q;
    logic [3:0]             miss_cnt_q;
    logic                   locked_q;
    logic                   error_pulse_q;
    logic [ERR_CNT_W-1:0]   err_count_q;

    logic                   pred;
    logic                   mismatch;
    logic [4:0]             seed_hist_d;
    logic [4:0]             lock_hist_d;
    logic [ERR_CNT_W-1:0]   err_count_d;

    always_comb begin
        pred        = hist_q[3] ^ hist_q[4];
        mismatch    = bit_in ^ pred;
        seed_hist_d = {hist_q[3:0], bit_in};
        // Once locked the history runs on predictions, so a flipped bit never pollutes later predictions.
        lock_hist_d = {hist_q[3:0], pred};
        err_count_d = (err_count_q == {ERR_CNT_W{1'b1}}) ? err_count_q : err_count_q + ERR_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SEED;
            hist_q        <= 5'd0;
            seed_cnt_q    <= 3'd0;
            match_cnt_q   <= 8'd0;
            miss_cnt_q    <= 4'd0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            error_pulse_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    ST_SEED: begin
                        hist_q <= seed_hist_d;
                        if (seed_cnt_q == 3'd4) begin
                            seed_cnt_q <= 3'd0;
                            // An all-zero seed would predict zeros forever; keep collecting instead.
                            if (seed_hist_d != 5'd0) begin
                                state_q     <= ST_VERIFY;
                                match_cnt_q <= 8'd0;
                            end
                        end else begin
                            seed_cnt_q <= seed_cnt_q + 3'd1;
                        end
                    end
                    ST_VERIFY: begin
                        hist_q <= seed_hist_d;
                        if (!mismatch) begin
                            match_cnt_q <= match_cnt_q + 8'd1;
                            if (match_cnt_q + 8'd1 == LOCK_CNT_L) begin
                                state_q    <= ST_LOCKED;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= 4'd0;
                            end
                        end else begin
                            state_q    <= ST_SEED;
                            seed_cnt_q <= 3'd1;
                        end
                    end
                    ST_LOCKED: begin
                        hist_q <= lock_hist_d;
                        if (mismatch) begin
                            error_pulse_q <= 1'b1;
                            err_count_q   <= err_count_d;
                            if (miss_cnt_q + 4'd1 == LOSS_THR_L) begin
                                state_q    <= ST_SEED;
                                locked_q   <= 1'b0;
                                seed_cnt_q <= 3'd0;
                                miss_cnt_q <= 4'd0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + 4'd1;
                            end
                        end else begin
                            miss_cnt_q <= 4'd0;
                        end
                    end
                    default: state_q <= ST_SEED;
                endcase
            end
            if (clear_cnt) begin
                err_count_q <= '0;
            end
        end
    end

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign err_count   = err_count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// tb/tb_prbs_stream_checker.sv - directed self-checking bench for prbs_stream_checker
module tb_prbs_stream_checker;

    localparam int ERR_CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 clear_cnt;
    logic                 locked;
    logic                 error_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [1:0]           state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int idx      = 0;
    int tally;
    logic stream [0:1023];

    always #5 clk = ~clk;

    prbs_stream_checker #(
        .LOCK_COUNT (8),
        .LOSS_THRESH(3),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear_cnt  (clear_cnt),
        .locked     (locked),
        .error_pulse(error_pulse),
        .err_count  (err_count),
        .state_o    (state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, return 1ns after the rising edge so outputs can be sampled.
    task automatic send(input logic b, input logic v, input logic clr);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_good();
        send(stream[idx], 1'b1, 1'b0);
        idx++;
    endtask

    task automatic send_bad(input logic clr);
        send(~stream[idx], 1'b1, clr);
        idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clear_cnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        stream[0] = 1'b0; stream[1] = 1'b0; stream[2] = 1'b1; stream[3] = 1'b1; stream[4] = 1'b0;
        for (int n = 5; n < 1024; n++) stream[n] = stream[n-4] ^ stream[n-5];

        reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_pulse", 32'(error_pulse), 0);
        check_eq("rst_count", 32'(err_count), 0);
        check_eq("rst_state", 32'(state_o), 0);
        reset = 1'b1;

        // Continuous stream: VERIFY after 5 bits, LOCKED after 13.
        for (int k = 1; k <= 13; k++) begin
            send_good();
            if (k == 4)  check_eq("seed4_state", 32'(state_o), 0);
            if (k == 5)  check_eq("seed5_state", 32'(state_o), 1);
            if (k == 12) check_eq("ver12_locked", 32'(locked), 0);
            if (k == 13) check_eq("ver13_locked", 32'(locked), 1);
            if (k == 13) check_eq("ver13_state", 32'(state_o), 2);
        end
        tally = 0;
        for (int k = 14; k <= 200; k++) begin
            send_good();
            if (error_pulse !== 1'b0 || locked !== 1'b1) tally++;
        end
        check_eq("clean200_glitches", 32'(tally), 0);
        check_eq("clean200_count", 32'(err_count), 0);

        // Single corrupted bit.
        send_bad(1'b0);
        check_eq("single_pulse", 32'(error_pulse), 1);
        check_eq("single_count", 32'(err_count), 1);
        check_eq("single_locked", 32'(locked), 1);
        tally = 0;
        for (int k = 0; k < 20; k++) begin
            send_good();
            tally += int'(error_pulse);
        end
        check_eq("single_after_pulses", 32'(tally), 0);
        check_eq("single_after_count", 32'(err_count), 1);

        // Three consecutive errors drop lock; clean stream relocks 13 bits later.
        for (int k = 1; k <= 3; k++) begin
            send_bad(1'b0);
            check_eq("loss_pulse", 32'(error_pulse), 1);
            check_eq("loss_locked", 32'(locked), (k < 3) ? 1 : 0);
        end
        check_eq("loss_state", 32'(state_o), 0);
        check_eq("loss_count", 32'(err_count), 4);
        for (int k = 1; k <= 13; k++) begin
            send_good();
            if (k == 12) check_eq("relock12", 32'(locked), 0);
            if (k == 13) check_eq("relock13", 32'(locked), 1);
        end
        check_eq("relock_count", 32'(err_count), 4);

        // Clear wins over a simultaneous error, the pulse still fires.
        send_bad(1'b1);
        check_eq("clr_err_count", 32'(err_count), 0);
        check_eq("clr_err_pulse", 32'(error_pulse), 1);
        send_good();
        check_eq("clr_after_pulse", 32'(error_pulse), 0);
        check_eq("clr_after_locked", 32'(locked), 1);

        // Twenty isolated errors saturate a 4-bit counter.
        for (int k = 0; k < 20; k++) begin
            send_bad(1'b0);
            send_good();
        end
        check_eq("sat_count", 32'(err_count), 15);
        check_eq("sat_locked", 32'(locked), 1);

        // Pulse drops on an invalid cycle; gap leaves state alone.
        send_bad(1'b0);
        check_eq("gap_err_pulse", 32'(error_pulse), 1);
        send(1'b1, 1'b0, 1'b0);
        check_eq("gap_pulse_low", 32'(error_pulse), 0);
        send(1'b0, 1'b0, 1'b0);
        send_good();
        check_eq("gap_resume_pulse", 32'(error_pulse), 0);
        check_eq("gap_resume_locked", 32'(locked), 1);
        send(1'b0, 1'b0, 1'b1);
        check_eq("clr_only", 32'(err_count), 0);

        // Zero stream never leaves SEED.
        do_reset();
        tally = 0;
        for (int k = 0; k < 50; k++) begin
            send(1'b0, 1'b1, 1'b0);
            if (state_o !== 2'd0 || locked !== 1'b0) tally++;
        end
        check_eq("zero_state", 32'(tally), 0);
        check_eq("zero_count", 32'(err_count), 0);

        // Valid every other cycle: lock point counted in valid bits.
        do_reset();
        idx = 0;
        for (int k = 1; k <= 13; k++) begin
            send(~stream[idx], 1'b0, 1'b0);
            send_good();
            if (k == 4)  check_eq("gapped_seed4", 32'(state_o), 0);
            if (k == 5)  check_eq("gapped_seed5", 32'(state_o), 1);
            if (k == 12) check_eq("gapped_lock12", 32'(locked), 0);
            if (k == 13) check_eq("gapped_lock13", 32'(locked), 1);
        end
        send(1'b1, 1'b0, 1'b0);
        check_eq("gapped_hold_state", 32'(state_o), 2);

        // Asynchronous reset while LOCKED clears outputs without a clock edge.
        send_bad(1'b0);
        check_eq("pre_rst_count", 32'(err_count), 1);
        reset = 1'b0;
        #1;
        check_eq("async_locked", 32'(locked), 0);
        check_eq("async_pulse", 32'(error_pulse), 0);
        check_eq("async_count", 32'(err_count), 0);
        check_eq("async_state", 32'(state_o), 0);
        @(negedge clk);
        reset = 1'b1;
        send(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
